// File: rtl/branch_resolve_unit_if.sv
// Request/result bundle for the branch resolve unit: request handshake in, resolved outcome out,
// plus the running event counters.
interface branch_resolve_unit_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_kind;
   logic [2:0]       in_op;
   logic [XLEN-1:0]  in_rs1;
   logic [XLEN-1:0]  in_rs2;
   logic [XLEN-1:0]  in_pc;
   logic [XLEN-1:0]  in_imm;
   logic [XLEN-1:0]  in_pred_target;
   logic             in_pred_taken;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [TAG_W-1:0] out_tag;
   logic             out_taken;
   logic             out_mispredict;
   logic             out_illegal;
   logic [XLEN-1:0]  out_target;
   logic [XLEN-1:0]  out_link;

   logic [31:0]      stat_resolved;
   logic [31:0]      stat_mispredict;

   modport slave (
      input  in_valid, in_kind, in_op, in_rs1, in_rs2, in_pc, in_imm, in_pred_target,
             in_pred_taken, in_tag, out_ready,
      output in_ready, out_valid, out_tag, out_taken, out_mispredict, out_illegal,
             out_target, out_link, stat_resolved, stat_mispredict
   );

   modport master (
      output in_valid, in_kind, in_op, in_rs1, in_rs2, in_pc, in_imm, in_pred_target,
             in_pred_taken, in_tag, out_ready,
      input  in_ready, out_valid, out_tag, out_taken, out_mispredict, out_illegal,
             out_target, out_link, stat_resolved, stat_mispredict
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolver: DEPTH-entry request FIFO feeding a combinational resolver whose
// outcome is captured in a single result register with valid/ready output.
module branch_resolve_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4,
   parameter int DEPTH = 4
) (
   input logic                 clk,
   input logic                 rst,
   input logic                 flush,
   branch_resolve_unit_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [1:0]       kind;
      logic [2:0]       op;
      logic [XLEN-1:0]  rs1;
      logic [XLEN-1:0]  rs2;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  imm;
      logic [XLEN-1:0]  pred_target;
      logic             pred_taken;
      logic [TAG_W-1:0] tag;
   } req_t;

   req_t             mem [DEPTH];
   req_t             wr_req;
   req_t             head_p0;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push;
   logic             pop;

   logic             taken_p0;
   logic             illegal_p0;
   logic             mispredict_p0;
   logic [XLEN-1:0]  seq_p0;
   logic [XLEN-1:0]  jalr_sum_p0;
   logic [XLEN-1:0]  target_p0;

   logic             vld_p1;
   logic             hs_p1;
   logic [TAG_W-1:0] tag_p1;
   logic             taken_p1;
   logic             mispredict_p1;
   logic             illegal_p1;
   logic [XLEN-1:0]  target_p1;
   logic [XLEN-1:0]  link_p1;
   logic [31:0]      resolved_cnt;
   logic [31:0]      mispredict_cnt;

   function automatic logic cond_taken(input logic [2:0] op, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
      logic signed [XLEN-1:0] sa;
      logic signed [XLEN-1:0] sb;
      sa = a;
      sb = b;
      cond_taken = 1'b0;
      case (op)
         3'b000:  cond_taken = (a == b);
         3'b001:  cond_taken = (a != b);
         3'b100:  cond_taken = (sa < sb);
         3'b101:  cond_taken = (sa >= sb);
         3'b110:  cond_taken = (a < b);
         3'b111:  cond_taken = (a >= b);
         default: cond_taken = 1'b0;
      endcase
   endfunction

   assign wr_req = '{kind: bus.in_kind, op: bus.in_op, rs1: bus.in_rs1, rs2: bus.in_rs2,
                     pc: bus.in_pc, imm: bus.in_imm, pred_target: bus.in_pred_target,
                     pred_taken: bus.in_pred_taken, tag: bus.in_tag};

   // No bypass: a full FIFO refuses input even if the head is leaving this cycle.
   assign bus.in_ready = (count != FULL);
   assign push         = bus.in_valid && bus.in_ready && !flush;
   assign hs_p1        = vld_p1 && bus.out_ready;
   assign pop          = (count != '0) && (!vld_p1 || bus.out_ready);
   assign head_p0      = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_req;
   end

   // Stage p0: resolve the FIFO head combinationally
   always_comb begin
      taken_p0    = 1'b0;
      illegal_p0  = 1'b0;
      seq_p0      = head_p0.pc + XLEN'(4);
      jalr_sum_p0 = head_p0.rs1 + head_p0.imm;
      target_p0   = seq_p0;
      case (head_p0.kind)
         2'b00: begin
            if (head_p0.op[2:1] == 2'b01) begin
               illegal_p0 = 1'b1;
            end else begin
               taken_p0 = cond_taken(head_p0.op, head_p0.rs1, head_p0.rs2);
               if (taken_p0) target_p0 = head_p0.pc + head_p0.imm;
            end
         end
         2'b01: begin
            taken_p0  = 1'b1;
            target_p0 = head_p0.pc + head_p0.imm;
         end
         2'b10: begin
            taken_p0  = 1'b1;
            target_p0 = {jalr_sum_p0[XLEN-1:1], 1'b0};
         end
         default: illegal_p0 = 1'b1;
      endcase
      mispredict_p0 = !illegal_p0 &&
                      ((taken_p0 != head_p0.pred_taken) ||
                       (taken_p0 && (target_p0 != head_p0.pred_target)));
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         vld_p1 <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (pop)        vld_p1 <= 1'b1;
         else if (hs_p1) vld_p1 <= 1'b0;
      end
   end

   // Stage p1: result register, only reloaded when empty or draining
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_p1        <= '0;
         taken_p1      <= 1'b0;
         mispredict_p1 <= 1'b0;
         illegal_p1    <= 1'b0;
         target_p1     <= '0;
         link_p1       <= '0;
      end else if (pop) begin
         tag_p1        <= head_p0.tag;
         taken_p1      <= taken_p0;
         mispredict_p1 <= mispredict_p0;
         illegal_p1    <= illegal_p0;
         target_p1     <= target_p0;
         link_p1       <= seq_p0;
      end
   end

   // Counters see only reset; flush leaves them alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         resolved_cnt   <= '0;
         mispredict_cnt <= '0;
      end else if (hs_p1) begin
         resolved_cnt <= resolved_cnt + 32'd1;
         if (mispredict_p1) mispredict_cnt <= mispredict_cnt + 32'd1;
      end
   end

   assign bus.out_valid       = vld_p1;
   assign bus.out_tag         = tag_p1;
   assign bus.out_taken       = taken_p1;
   assign bus.out_mispredict  = mispredict_p1;
   assign bus.out_illegal     = illegal_p1;
   assign bus.out_target      = target_p1;
   assign bus.out_link        = link_p1;
   assign bus.stat_resolved   = resolved_cnt;
   assign bus.stat_mispredict = mispredict_cnt;
endmodule
